// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//
// Shares the register file's single write port among NUM_REQ producers.
// A round-robin arbiter grants one requester per cycle, and the winning
// write is registered into a one-stage pipeline that drives the register
// file write port. The in-flight write is forwarded onto both read ports,
// so consumers never see stale data. Writes to address 0 are accepted but
// never reach the register file. Instead they are counted in a saturating
// drop counter.
//
// Ports:
//   clk, reset                   - clock, asynchronous active-high reset
//   req_valid/req_addr/req_data  - per-requester write requests (packed slices)
//   req_ready                    - one-hot combinational grant
//   rf_we/rf_wr_addr/rf_wr_data  - registered register file write port
//   rd_addr_a/b                  - read addresses (shared with register file)
//   rf_rd_data_a/b               - raw register file read data
//   rd_data_a/b                  - forwarded read data for consumers
//   drop_count                   - saturating count of accepted writes to addr 0
module regfile_wr_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int NUM_ADDR_BITS = 6,
  parameter int REG_WIDTH     = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*NUM_ADDR_BITS-1:0] req_addr,
  input  logic [NUM_REQ*REG_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rf_we,
  output logic [NUM_ADDR_BITS-1:0]       rf_wr_addr,
  output logic [REG_WIDTH-1:0]           rf_wr_data,
  input  logic [NUM_ADDR_BITS-1:0]       rd_addr_a,
  input  logic [NUM_ADDR_BITS-1:0]       rd_addr_b,
  input  logic [REG_WIDTH-1:0]           rf_rd_data_a,
  input  logic [REG_WIDTH-1:0]           rf_rd_data_b,
  output logic [REG_WIDTH-1:0]           rd_data_a,
  output logic [REG_WIDTH-1:0]           rd_data_b,
  output logic [15:0]                    drop_count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_ADDR_BITS-1:0] ZERO_ADDR = {NUM_ADDR_BITS{1'b0}};

  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic                     rf_we_q, rf_we_d;
  logic [NUM_ADDR_BITS-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [REG_WIDTH-1:0]     rf_wr_data_q, rf_wr_data_d;
  logic [15:0]              drop_count_q, drop_count_d;

  logic [IDX_W-1:0]         cand_idx;
  logic [IDX_W-1:0]         win_idx;
  logic                     transfer;
  logic [NUM_ADDR_BITS-1:0] win_addr;
  logic [REG_WIDTH-1:0]     win_data;

  // Read-data bypass: address 0 reads as zero, an in-flight write to the
  // same address overrides the (not yet updated) register file output.
  function automatic logic [REG_WIDTH-1:0] fwd_sel(
    input logic [NUM_ADDR_BITS-1:0] rd_addr,
    input logic [REG_WIDTH-1:0]     raw_data,
    input logic                     we,
    input logic [NUM_ADDR_BITS-1:0] wr_addr,
    input logic [REG_WIDTH-1:0]     wr_data
  );
    logic [REG_WIDTH-1:0] res;
    if (rd_addr == ZERO_ADDR) begin
      res = {REG_WIDTH{1'b0}};
    end else if (we && (rd_addr == wr_addr)) begin
      res = wr_data;
    end else begin
      res = raw_data;
    end
    return res;
  endfunction

  // Round-robin winner search: first valid requester starting at ptr_q.
  always_comb begin
    cand_idx = {IDX_W{1'b0}};
    win_idx  = {IDX_W{1'b0}};
    transfer = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!transfer && req_valid[cand_idx]) begin
        transfer = 1'b1;
        win_idx  = cand_idx;
      end else begin
        transfer = transfer;
      end
    end
  end

  assign win_addr = req_addr[win_idx*NUM_ADDR_BITS +: NUM_ADDR_BITS];
  assign win_data = req_data[win_idx*REG_WIDTH +: REG_WIDTH];

  // One-hot grant; a valid requester always wins, so grant implies transfer.
  always_comb begin
    if (transfer) begin
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Next-state: pointer advance, write stage load and drop counting.
  always_comb begin
    ptr_d        = ptr_q;
    rf_we_d      = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    drop_count_d = drop_count_q;
    if (transfer) begin
      ptr_d        = (win_idx == LAST_IDX) ? {IDX_W{1'b0}} : (win_idx + IDX_W'(1));
      rf_wr_addr_d = win_addr;
      rf_wr_data_d = win_data;
      rf_we_d      = (win_addr != ZERO_ADDR);
      // Address 0 is hardwired in the register file; count the drop instead.
      if ((win_addr == ZERO_ADDR) && (drop_count_q != 16'hFFFF)) begin
        drop_count_d = drop_count_q + 16'd1;
      end else begin
        drop_count_d = drop_count_q;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers; reset discards the in-flight write immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= {IDX_W{1'b0}};
      rf_we_q      <= 1'b0;
      rf_wr_addr_q <= {NUM_ADDR_BITS{1'b0}};
      rf_wr_data_q <= {REG_WIDTH{1'b0}};
      drop_count_q <= 16'd0;
    end else begin
      ptr_q        <= ptr_d;
      rf_we_q      <= rf_we_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign drop_count = drop_count_q;

  // Forwarded read data for both ports.
  always_comb begin
    rd_data_a = fwd_sel(rd_addr_a, rf_rd_data_a, rf_we_q, rf_wr_addr_q, rf_wr_data_q);
    rd_data_b = fwd_sel(rd_addr_b, rf_rd_data_b, rf_we_q, rf_wr_addr_q, rf_wr_data_q);
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: table-driven arbitration vectors plus
// hand-written sequences, with a scoreboard queue of expected register
// file writes popped whenever the DUT asserts rf_we.
module tb_regfile_wr_arbiter;

  localparam int NR = 4;
  localparam int AW = 6;
  localparam int DW = 32;

  logic           clk;
  logic           reset;
  logic [NR-1:0]  req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           rf_we;
  logic [AW-1:0]  rf_wr_addr;
  logic [DW-1:0]  rf_wr_data;
  logic [AW-1:0]  rd_addr_a, rd_addr_b;
  logic [DW-1:0]  rf_rd_data_a, rf_rd_data_b;
  logic [DW-1:0]  rd_data_a, rd_data_b;
  logic [15:0]    drop_count;

  regfile_wr_arbiter #(.NUM_REQ(NR), .NUM_ADDR_BITS(AW), .REG_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .drop_count(drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model; entry 0 holds junk so zero-forcing is visible.
  logic [DW-1:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0] = 32'hBAD0_BAD0;
  end
  always @(posedge clk) if (rf_we) mem[rf_wr_addr] <= rf_wr_data;
  assign rf_rd_data_a = mem[rd_addr_a];
  assign rf_rd_data_b = mem[rd_addr_b];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every register file write must match the oldest expected one.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(rf_wr_addr), 64'hFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("sb_wr_addr", 64'(rf_wr_addr), 64'(e.addr));
        check("sb_wr_data", 64'(rf_wr_data), 64'(e.data));
      end
    end
  end

  task automatic idle();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] vaddr(input int v, input int i);
    return AW'(v * 4 + i + 1);
  endfunction

  function automatic logic [DW-1:0] vdata(input int v, input int i);
    return 32'hC0DE_0000 | DW'(v * 16 + i);
  endfunction

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] exp_ready;
  } vec_t;
  vec_t vecs[12];

  logic [DW-1:0] saved9;

  initial begin
    // Hand-derived from ptr=0 after reset; pointer after each row in comment.
    vecs[0]  = '{4'b1100, 4'b0100}; // ptr 3
    vecs[1]  = '{4'b1001, 4'b1000}; // ptr 0
    vecs[2]  = '{4'b0000, 4'b0000}; // ptr 0 (hold)
    vecs[3]  = '{4'b0001, 4'b0001}; // ptr 1
    vecs[4]  = '{4'b0001, 4'b0001}; // ptr 1 (wrap)
    vecs[5]  = '{4'b1111, 4'b0010}; // ptr 2
    vecs[6]  = '{4'b1011, 4'b1000}; // ptr 0
    vecs[7]  = '{4'b0110, 4'b0010}; // ptr 2
    vecs[8]  = '{4'b0100, 4'b0100}; // ptr 3
    vecs[9]  = '{4'b0011, 4'b0001}; // ptr 1
    vecs[10] = '{4'b1001, 4'b1000}; // ptr 0
    vecs[11] = '{4'b1111, 4'b0001}; // ptr 1

    reset = 1'b1;
    idle();
    rd_addr_a = '0;
    rd_addr_b = '0;
    #2;
    req_valid = 4'b0100;
    #1;
    check("ready_in_reset", 64'(req_ready), 64'(4'b0100));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_wr_addr", 64'(rf_wr_addr), 64'd0);
    check("rst_wr_data", 64'(rf_wr_data), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);

    // Table-driven arbitration vectors, one per cycle.
    for (int v = 0; v < 12; v++) begin
      idle();
      for (int i = 0; i < NR; i++)
        if (vecs[v].valid[i]) set_req(i, vaddr(v, i), vdata(v, i));
      #2;
      check($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(vecs[v].exp_ready));
      for (int i = 0; i < NR; i++)
        if (vecs[v].exp_ready[i]) push_exp(vaddr(v, i), vdata(v, i));
      tick();
    end
    idle();

    // Single write with forwarding, then raw read one cycle later.
    set_req(0, 6'd5, 32'hDEAD_BEEF);
    #2;
    check("single_ready", 64'(req_ready), 64'(4'b0001));
    push_exp(6'd5, 32'hDEAD_BEEF);
    tick();
    idle();
    rd_addr_a = 6'd5;
    #2;
    check("single_we", 64'(rf_we), 64'd1);
    check("single_fwd_a", 64'(rd_data_a), 64'(32'hDEAD_BEEF));
    tick();
    #2;
    check("single_we_off", 64'(rf_we), 64'd0);
    check("single_raw_a", 64'(rd_data_a), 64'(32'hDEAD_BEEF));

    // Pointer hold across idle cycles (ptr currently 1).
    set_req(1, 6'd10, 32'h0000_0110);
    #2;
    check("hold_grant1", 64'(req_ready), 64'(4'b0010));
    push_exp(6'd10, 32'h0000_0110);
    tick();
    idle();
    tick(); tick(); tick();
    for (int i = 0; i < NR; i++) set_req(i, AW'(20 + i), DW'(32'h200 + i));
    #2;
    check("hold_next_grant", 64'(req_ready), 64'(4'b0100));
    push_exp(6'd22, 32'h0000_0202);
    tick();
    idle();

    // Back-to-back writes to addr 7 observed on both read ports (ptr 3).
    set_req(0, 6'd7, 32'hA);
    #2;
    check("fwd_grant0", 64'(req_ready), 64'(4'b0001));
    push_exp(6'd7, 32'hA);
    tick();
    idle();
    set_req(1, 6'd7, 32'hB);
    rd_addr_a = 6'd7;
    rd_addr_b = 6'd7;
    #2;
    check("fwd_grant1", 64'(req_ready), 64'(4'b0010));
    push_exp(6'd7, 32'hB);
    check("fwd_a_A", 64'(rd_data_a), 64'hA);
    check("fwd_b_A", 64'(rd_data_b), 64'hA);
    tick();
    idle();
    #2;
    check("fwd_a_B", 64'(rd_data_a), 64'hB);
    check("fwd_b_B", 64'(rd_data_b), 64'hB);
    tick();
    #2;
    check("raw_a_B", 64'(rd_data_a), 64'hB);
    check("raw_b_B", 64'(rd_data_b), 64'hB);

    // Write to address 0 is accepted but dropped (ptr 2).
    set_req(3, 6'd0, 32'h1);
    #2;
    check("a0_ready", 64'(req_ready), 64'(4'b1000));
    tick();
    idle();
    rd_addr_b = 6'd0;
    #2;
    check("a0_we", 64'(rf_we), 64'd0);
    check("a0_drop1", 64'(drop_count), 64'd1);
    check("a0_rd_b", 64'(rd_data_b), 64'd0);

    // Drive the drop counter up to saturation.
    set_req(3, 6'd0, 32'h1);
    repeat (65533) @(posedge clk);
    #1;
    check("drop_fffe", 64'(drop_count), 64'hFFFE);
    tick();
    check("drop_ffff", 64'(drop_count), 64'hFFFF);
    tick(); tick();
    check("drop_sat", 64'(drop_count), 64'hFFFF);
    idle();

    // Asynchronous reset while a write is in flight.
    saved9 = mem[9];
    set_req(0, 6'd9, 32'h99);
    tick();
    idle();
    check("ar_we_before", 64'(rf_we), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("ar_we", 64'(rf_we), 64'd0);
    check("ar_wr_addr", 64'(rf_wr_addr), 64'd0);
    check("ar_wr_data", 64'(rf_wr_data), 64'd0);
    check("ar_drop", 64'(drop_count), 64'd0);
    tick();
    reset = 1'b0;
    rd_addr_a = 6'd9;
    #1;
    check("ar_rf_unchanged", 64'(rd_data_a), 64'(saved9));

    // Fairness from ptr=0 with everyone valid for 8 cycles.
    for (int k = 0; k < 8; k++) begin
      idle();
      for (int i = 0; i < NR; i++) set_req(i, AW'(30 + i), DW'(32'h3000 + k * 16 + i));
      #2;
      check($sformatf("fair%0d_ready", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
      push_exp(AW'(30 + k % 4), DW'(32'h3000 + k * 16 + k % 4));
      if (k > 0) check($sformatf("fair%0d_we", k), 64'(rf_we), 64'd1);
      tick();
    end
    idle();
    #2;
    check("fair_last_we", 64'(rf_we), 64'd1);
    tick();
    #2;
    check("fair_we_off", 64'(rf_we), 64'd0);

    tick(); tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
